// File: rtl/ram_filler_pkg.sv
// Shared definitions for the RAM filler: fill modes, FSM states and the
// LFSR used by the pseudo-random fill pattern.
package ram_filler_pkg;

    // Fill pattern selector, latched when a fill starts.
    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_ADDR  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_LFSR  = 2'd3
    } fill_mode_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DONE     = 2'd3
    } fill_state_e;

    // LFSR seed, reloaded at every fill start so a fill is reproducible.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form:
    // polynomial terms 16,14,13,11 map onto state bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // One LFSR step: feedback is the parity of the tapped bits, shifted in at the top.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/ram_filler_pattern.sv
// Pattern generator for the RAM filler: combinational data for the current
// position and mode, plus the LFSR state that feeds the pseudo-random mode.
module fill_pattern_gen
    import ram_filler_pkg::*;
#(
    parameter int              DW   = 8,
    parameter logic [DW-1:0]   FILL = 8'hFF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ena,
    input  logic          seed_i,
    input  logic          advance_i,
    input  logic [DW-1:0] pos_i,
    input  logic [1:0]    mode_i,
    output logic [DW-1:0] pattern_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next LFSR state: reseed on fill start, step once per committed write.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_i) begin
            lfsr_d = LFSR_SEED;
        end else if (advance_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    // LFSR register, frozen while the clock enable is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (ena) begin
            lfsr_q <= lfsr_d;
        end
    end

    // Pattern selection for the word at pos_i.
    always_comb begin
        pattern_o = FILL;
        case (fill_mode_e'(mode_i))
            MODE_CONST: pattern_o = FILL;
            MODE_ADDR:  pattern_o = pos_i;
            MODE_CHECK: pattern_o = pos_i[0] ? ~FILL : FILL;
            MODE_LFSR:  pattern_o = lfsr_q[DW-1:0];
            default:    pattern_o = FILL;
        endcase
    end

endmodule

// File: rtl/ram_filler.sv
// RAM filler: walks the inclusive range [START_RAM..END_RAM] issuing one
// handshaked write per address with a selectable data pattern. Can be
// aborted; signals completion with a single-cycle done pulse.
module ram_filler
    import ram_filler_pkg::*;
#(
    parameter int            AW        = 25,
    parameter int            DW        = 8,
    parameter logic [AW-1:0] START_RAM = 25'h0,
    parameter logic [AW-1:0] END_RAM   = 25'h1FFFF,
    parameter logic [DW-1:0] FILL      = 8'hFF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ena,
    input  logic          trigger,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic          ack,
    output logic          busy,
    output logic          done,
    output logic          wr,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    // An empty or inverted range is a configuration error caught at elaboration.
    if (START_RAM > END_RAM) begin : g_range_check
        $error("ram_filler: START_RAM must not exceed END_RAM");
    end

    fill_state_e   state_q;
    logic          trigger_q;
    logic [1:0]    mode_q;
    logic [AW-1:0] pos_q;
    logic          busy_q;
    logic          done_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    logic          trig_edge;
    logic          lfsr_seed;
    logic          lfsr_advance;
    logic [DW-1:0] pattern;

    // Start request is a rising edge; a held trigger never restarts a fill.
    assign trig_edge    = trigger & ~trigger_q;
    // LFSR restarts with each fill and steps only on writes that commit
    // (an abort in the same cycle as ack cancels the commit).
    assign lfsr_seed    = (state_q == ST_IDLE) && trig_edge;
    assign lfsr_advance = (state_q == ST_WAIT_ACK) && ack && !abort;

    fill_pattern_gen #(
        .DW   (DW),
        .FILL (FILL)
    ) u_pattern (
        .clk       (clk),
        .reset_n   (reset_n),
        .ena       (ena),
        .seed_i    (lfsr_seed),
        .advance_i (lfsr_advance),
        .pos_i     (pos_q[DW-1:0]),
        .mode_i    (mode_q),
        .pattern_o (pattern)
    );

    // Fill controller: sequencing, position counter and registered write port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            trigger_q <= 1'b0;
            mode_q    <= 2'd0;
            pos_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else if (ena) begin
            trigger_q <= trigger;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (trig_edge) begin
                        mode_q  <= mode;
                        pos_q   <= START_RAM;
                        busy_q  <= 1'b1;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (abort) begin
                        wr_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        wr_q    <= 1'b1;
                        addr_q  <= pos_q;
                        data_q  <= pattern;
                        state_q <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // wr/addr/data stay put until the write is accepted.
                    if (abort) begin
                        wr_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (ack) begin
                        wr_q <= 1'b0;
                        // Compare before incrementing so END_RAM = 2^AW-1 cannot wrap.
                        if (pos_q == END_RAM) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            pos_q   <= pos_q + AW'(1);
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign wr   = wr_q;
    assign addr = addr_q;
    assign data = data_q;

endmodule
